btoex_seq: RTL and testbench
============================

BTOEX_SEQ -- requirements
Module: btoex_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit digits per word (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, 4*NIBBLES bits: word to convert; nibble 0 is bits [3:0].
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-007 The block SHALL have port out_data, output, 4*NIBBLES bits: excess-3 result, same nibble order as in_data.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port err, output, 1 bit: invalid-BCD flag, present only under BTOEX_SEQ_ERR_EN (REQ-027).

Function
REQ-012 The block SHALL share one 4-bit converter (op = inp + 3, modulo 16) across all nibbles, one nibble per cycle.
REQ-013 The FSM SHALL have states IDLE, CONV and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; all other states SHALL drive in_ready 0.
REQ-015 On an edge with in_valid=1 and in_ready=1, the block SHALL latch in_data, clear the nibble index to 0, clear the result register and move to CONV.
REQ-016 In CONV, each edge SHALL write the converter output for nibble[idx] into result nibble[idx] and increment idx; idx SHALL go 0 to NIBBLES-1, LSB nibble first.
REQ-017 On the edge that writes nibble NIBBLES-1, the FSM SHALL move to DONE; out_valid SHALL be high exactly NIBBLES cycles after the accepting edge.
REQ-018 In DONE, out_valid SHALL be 1 and out_data SHALL hold stable until an edge with out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-019 out_valid SHALL be 0 in IDLE and CONV; out_ready SHALL be ignored outside DONE.
REQ-020 in_valid and in_data changes during CONV or DONE SHALL have no effect; the latched word alone is converted.
REQ-021 Overflow SHALL wrap: nibble 0xD->0x0, 0xE->0x1, 0xF->0x2; no carry SHALL propagate between nibbles.
REQ-022 Back-to-back words SHALL have a throughput of one word per NIBBLES+2 cycles when out_ready is held at 1 (there is no IDLE bypass).
REQ-023 out_data SHALL keep its last value after the output handshake, until the next accept clears it.

Reset
REQ-024 When rst=1 at an edge, the FSM SHALL go to IDLE with idx=0, out_data=0, out_valid=0, busy=0, err=0 (if present) and in_ready=1 after the edge; rst SHALL take priority over all handshakes.
REQ-025 A reset asserted during CONV or DONE SHALL abort the word with no output handshake; the first accept after reset SHALL convert cleanly.

Configuration
REQ-026 The macro BTOEX_SEQ_ERR_EN SHALL select the BCD-check feature.
REQ-027 With BTOEX_SEQ_ERR_EN defined, the err port SHALL exist.
- err SHALL be cleared on accept.
- err SHALL be set sticky in CONV when any processed nibble is greater than 9.
- err SHALL be valid with out_valid and held through DONE.
- Conversion SHALL still proceed with wrap per REQ-021.
REQ-028 With BTOEX_SEQ_ERR_EN undefined, the err port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 NIBBLES=4: accept in_data=16'h1234 with out_ready=1 -> out_valid high 4 cycles after accept, out_data=16'h4567, then IDLE (in_ready=1) on the next edge.
REQ-030 Accept 16'h0909 with out_ready=0 for 10 cycles -> out_data=16'h3C3C held stable and out_valid=1 throughout; handshake on the first out_ready=1 edge.
REQ-031 Accept 16'hFFFF -> out_data=16'h2222; with BTOEX_SEQ_ERR_EN, err=1; accept 16'h9876 -> err=0, out_data=16'hCBA9.
REQ-032 Toggle in_valid and in_data=16'hAAAA during CONV of 16'h0000 -> out_data=16'h3333 and in_ready=0 throughout CONV.
REQ-033 Assert rst for 1 cycle at idx=2 during CONV -> next cycle IDLE, out_valid=0, out_data=0; a following 16'h5555 yields 16'h8888.
REQ-034 Sweep 16 single-digit values 0..F in every nibble position with random out_ready stalls -> every nibble equals (v+3) mod 16; no word lost or duplicated.

Source files
------------

// File: rtl/btoex_seq.sv
// Sequential BCD to excess-3 converter: one shared 4-bit adder walks the word LSB nibble first.
// Optional invalid-BCD flag (err) is built when BTOEX_SEQ_ERR_EN is defined.
module btoex_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
`ifdef BTOEX_SEQ_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [IdxW-1:0]      r_idx;
  logic [4*NIBBLES-1:0] r_word;
  logic [4*NIBBLES-1:0] r_result;

  logic [3:0] w_nib;
  logic [3:0] w_conv;
  logic       w_last;
  logic       w_accept;

  always_comb begin
    w_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IdxW'(i)) w_nib = r_word[4*i +: 4];
    end
  end

  // Modulo-16 add: 0xD..0xF wrap to 0x0..0x2, no carry into the next nibble.
  assign w_conv   = w_nib + 4'd3;
  assign w_last   = (r_idx == IdxW'(NIBBLES - 1));
  assign w_accept = in_valid && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_word   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_word   <= in_data;
            r_idx    <= '0;
            r_result <= '0;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IdxW'(i)) r_result[4*i +: 4] <= w_conv;
          end
          if (w_last) begin
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BTOEX_SEQ_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((r_state == S_CONV) && (w_nib > 4'd9)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_result;

endmodule

// File: tb/tb_btoex_seq.sv
// Scoreboard bench for btoex_seq: driver pushes model results, negedge monitor pops on output.
// Also checks err when compiled with BTOEX_SEQ_ERR_EN.
module tb_btoex_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
`ifdef BTOEX_SEQ_ERR_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  btoex_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef BTOEX_SEQ_ERR_EN
    ,
    .err       (err)
`endif
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   passed    = 0;
  int   words_in  = 0;
  int   words_out = 0;
  int   mode      = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got %0h, required none", name, act);
  endtask

  // Reference: each digit independently becomes (v + 3) mod 16; any digit above 9 is invalid BCD.
  function automatic exp_t model(input logic [W-1:0] w);
    exp_t r;
    int   v;
    r.d = '0;
    r.e = 1'b0;
    for (int i = 0; i < N; i++) begin
      v   = int'((w >> (4 * i)) & W'(15));
      r.d = r.d | (W'((v + 3) % 16) << (4 * i));
      if (v > 9) r.e = 1'b1;
    end
    return r;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        fail_now("unexpected_word", 32'(out_data));
      end else begin
        chk("out_data", 32'(out_data), 32'(q[0].d));
`ifdef BTOEX_SEQ_ERR_EN
        chk("err", 32'(err), 32'(q[0].e));
`endif
        if (out_ready) begin
          void'(q.pop_front());
          words_out++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w, input bit push);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      fail_now("in_ready_timeout", 32'(t));
    end else begin
      in_valid = 1'b1;
      in_data  = w;
      if (push) begin
        q.push_back(model(w));
        words_in++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] w;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef BTOEX_SEQ_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;

    // Latency: out_valid rises exactly N edges after accept, IDLE on the edge after.
    mode = 0;
    send(16'h1234, 1'b1);
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      chk("lat_out_valid", 32'(out_valid), (k == N) ? 32'd1 : 32'd0);
      chk("lat_in_ready", 32'(in_ready), 32'd0);
      chk("lat_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_hold", 32'(out_data), 32'h4567);

    // Stall: result held for 10 cycles with out_ready low.
    mode = 2;
    send(16'h0909, 1'b1);
    repeat (N) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    mode = 0;
    wait_drain();

    send(16'hFFFF, 1'b1);
    send(16'h9876, 1'b1);
    wait_drain();

    // Input noise during CONV must not disturb the latched word.
    send(16'h0000, 1'b1);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("conv_in_ready", 32'(in_ready), 32'd0);
      in_valid = ~in_valid;
      in_data  = 16'hAAAA;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();

    // Reset at idx=2 aborts the word.
    send(16'h1234, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    send(16'h5555, 1'b1);
    wait_drain();

    // Sweep every digit value in every position, random backpressure.
    mode = 1;
    for (int p = 0; p < N; p++) begin
      for (int v = 0; v < 16; v++) begin
        w = W'($urandom);
        w[4*p +: 4] = 4'(v);
        send(w, 1'b1);
      end
    end
    for (int k = 0; k < 30; k++) send(W'($urandom), 1'b1);
    wait_drain();
    mode = 0;
    repeat (4) @(negedge clk);
    chk("word_count", 32'(words_out), 32'(words_in));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
